// File: rtl/and_stim_seq.sv
// Clocked stimulus sequencer for the two-input AND gate stage: four fixed (a,b) vectors,
// each held HOLDn cycles. Define AND_STIM_CHECK_EN to build the x_in mismatch checker.
module and_stim_seq #(
  parameter int HOLD_W = 5,
  parameter int HOLD0  = 5,
  parameter int HOLD1  = 10,
  parameter int HOLD2  = 15,
  parameter int HOLD3  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       x_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [1:0] step,
  output logic [7:0] err_count,
  output logic       mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        step_r, step_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic              accept;
  logic              last;
  logic              vec_a, vec_b;

  // Hold values are truncated to HOLD_W bits; zero is promoted to one cycle.
  function automatic logic [HOLD_W-1:0] hold_of(input logic [1:0] s);
    logic [HOLD_W-1:0] h;
    case (s)
      2'd0:    h = HOLD_W'(HOLD0);
      2'd1:    h = HOLD_W'(HOLD1);
      2'd2:    h = HOLD_W'(HOLD2);
      default: h = HOLD_W'(HOLD3);
    endcase
    if (h == '0) h = HOLD_W'(1);
    return h;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step_r <= 2'd0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      step_r <= step_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_r;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
          step_nxt  = 2'd0;
          cnt_nxt   = hold_of(2'd0);
        end
      end
      DRIVE: begin
        if (cnt <= HOLD_W'(1)) begin
          last = 1'b1;
          if (step_r != 2'd3) begin
            step_nxt = 2'(step_r + 2'd1);
            cnt_nxt  = hold_of(2'(step_r + 2'd1));
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt - HOLD_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector table: 0 -> 00, 1 -> 11, 2 -> 01, 3 -> 10 (a,b).
  always_comb begin
    vec_a = 1'b0;
    vec_b = 1'b0;
    case (step_r)
      2'd0:    begin vec_a = 1'b0; vec_b = 1'b0; end
      2'd1:    begin vec_a = 1'b1; vec_b = 1'b1; end
      2'd2:    begin vec_a = 1'b0; vec_b = 1'b1; end
      default: begin vec_a = 1'b1; vec_b = 1'b0; end
    endcase
  end

  assign a    = (state == DRIVE) & vec_a;
  assign b    = (state == DRIVE) & vec_b;
  assign busy = (state == DRIVE);
  assign done = (state == DONE);
  assign step = step_r;

`ifdef AND_STIM_CHECK_EN
  logic       fail;
  logic       mm_r;
  logic [7:0] err_r;

  // x_in is judged on the last cycle of each vector, giving the gate the full hold to settle.
  assign fail = last & (x_in != (a & b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_r  <= 1'b0;
      err_r <= 8'd0;
    end else begin
      mm_r <= fail;
      if (accept)
        err_r <= 8'd0;
      else if (fail && err_r != 8'hFF)
        err_r <= err_r + 8'd1;
    end
  end

  assign mismatch  = mm_r;
  assign err_count = err_r;
`else
  logic [1:0] unused_chk;
  assign unused_chk = {x_in, last};
  assign mismatch   = 1'b0;
  assign err_count  = 8'd0;
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
